// File: rtl/rx_stats_counter_pkg.sv
// Shared constants for the MAC receive statistics block: FSM encodings and
// the legal snapshot-period window.
package rx_stats_counter_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    // The downstream sampler needs each snapshot held for at least 16 cycles.
    localparam int SNAP_PERIOD_MIN = 16;
    localparam int SNAP_PERIOD_MAX = 65535;

endpackage

// File: rtl/rx_stats_counter_if.sv
// Receive-side beat/marker inputs and held snapshot outputs of rx_stats_counter.
interface rx_stats_counter_if #(
    parameter int W = 32
);
    logic [7:0]   rx_data_valid;
    logic         rx_good_frame;
    logic         rx_bad_frame;
    logic         clr;
    logic [W-1:0] good_frames_out;
    logic [W-1:0] bad_frames_out;
    logic [W-1:0] good_bytes_out;
    logic         snap_stb;

    modport master (
        output rx_data_valid, rx_good_frame, rx_bad_frame, clr,
        input  good_frames_out, bad_frames_out, good_bytes_out, snap_stb
    );

    modport slave (
        input  rx_data_valid, rx_good_frame, rx_bad_frame, clr,
        output good_frames_out, bad_frames_out, good_bytes_out, snap_stb
    );
endinterface

// File: rtl/rx_stats_counter_byte_lane_count.sv
// Number of valid byte lanes in one 64-bit MAC beat; any lane pattern allowed.
module byte_lane_count (
    input  logic [7:0] i_lanes,
    output logic [3:0] o_count
);
    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_lanes[i]};
        end
    end
endmodule

// File: rtl/rx_stats_counter.sv
// Good/bad frame and good-byte counters for the 10G MAC receive path, published
// as snapshots held for SNAP_PERIOD cycles for a downstream periodic CDC sampler.
module rx_stats_counter
    import rx_stats_counter_pkg::*;
#(
    parameter int W           = 32,
    parameter int SNAP_PERIOD = 64,
    parameter int LEN_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    rx_stats_counter_if.slave bus
);
    localparam int              PW          = $clog2(SNAP_PERIOD);
    localparam logic [PW-1:0]   PERIOD_LAST = PW'(SNAP_PERIOD - 1);

    generate
        if (SNAP_PERIOD < SNAP_PERIOD_MIN || SNAP_PERIOD > SNAP_PERIOD_MAX) begin : g_bad_period
            $error("rx_stats_counter: SNAP_PERIOD outside 16..65535");
        end
        if (LEN_W < 4) begin : g_bad_len
            $error("rx_stats_counter: LEN_W must hold at least one full beat");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_acc;
    logic [W-1:0]     r_good_frames;
    logic [W-1:0]     r_bad_frames;
    logic [W-1:0]     r_good_bytes;
    logic [PW-1:0]    r_period;
    logic [W-1:0]     r_snap_good_frames;
    logic [W-1:0]     r_snap_bad_frames;
    logic [W-1:0]     r_snap_good_bytes;
    logic             r_snap_stb;

    logic [3:0]       w_lane_bytes;
    logic [LEN_W-1:0] w_acc_base;
    logic [LEN_W:0]   w_acc_sum;
    logic [LEN_W-1:0] w_acc_next;
    logic [W-1:0]     w_frame_bytes;
    logic             w_end;
    logic             w_commit_good;
    logic             w_terminal;
    logic [0:0]       w_state_next;

    byte_lane_count u_lane_count (
        .i_lanes (bus.rx_data_valid),
        .o_count (w_lane_bytes)
    );

    // A marker seen in IDLE counts only the bytes of its own beat.
    assign w_acc_base    = (r_state == ST_IN_FRAME) ? r_acc : '0;
    assign w_acc_sum     = {1'b0, w_acc_base} + (LEN_W + 1)'(w_lane_bytes);
    assign w_acc_next    = w_acc_sum[LEN_W] ? '1 : w_acc_sum[LEN_W-1:0];
    assign w_frame_bytes = W'(w_acc_next);

    // Both markers together are treated as a bad frame.
    assign w_end         = bus.rx_good_frame | bus.rx_bad_frame;
    assign w_commit_good = bus.rx_good_frame & ~bus.rx_bad_frame;
    assign w_terminal    = (r_period == PERIOD_LAST);

    always_comb begin
        w_state_next = r_state;
        if (w_end) begin
            w_state_next = ST_IDLE;
        end else if (|bus.rx_data_valid) begin
            w_state_next = ST_IN_FRAME;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_acc              <= '0;
            r_good_frames      <= '0;
            r_bad_frames       <= '0;
            r_good_bytes       <= '0;
            r_period           <= '0;
            r_snap_good_frames <= '0;
            r_snap_bad_frames  <= '0;
            r_snap_good_bytes  <= '0;
            r_snap_stb         <= 1'b0;
        end else begin
            r_period   <= w_terminal ? '0 : r_period + PW'(1);
            r_snap_stb <= w_terminal;
            // Snapshot takes the live values as they stood before this cycle's commit.
            if (w_terminal) begin
                r_snap_good_frames <= r_good_frames;
                r_snap_bad_frames  <= r_bad_frames;
                r_snap_good_bytes  <= r_good_bytes;
            end

            if (bus.clr) begin
                r_state       <= ST_IDLE;
                r_acc         <= '0;
                r_good_frames <= '0;
                r_bad_frames  <= '0;
                r_good_bytes  <= '0;
            end else begin
                r_state <= w_state_next;
                r_acc   <= w_end ? '0 : w_acc_next;
                if (w_end) begin
                    if (w_commit_good) begin
                        r_good_frames <= r_good_frames + W'(1);
                        r_good_bytes  <= r_good_bytes + w_frame_bytes;
                    end else begin
                        r_bad_frames  <= r_bad_frames + W'(1);
                    end
                end
            end
        end
    end

    assign bus.good_frames_out = r_snap_good_frames;
    assign bus.bad_frames_out  = r_snap_bad_frames;
    assign bus.good_bytes_out  = r_snap_good_bytes;
    assign bus.snap_stb        = r_snap_stb;

endmodule

// File: doc/rx_stats_counter.md
Name: rx_stats_counter

Overview:
Counts good frames, bad frames and good-frame bytes from the 10G MAC receive interface in the MAC clock domain. Counters are published as periodic, held snapshots. Each snapshot stays stable for SNAP_PERIOD cycles, so a downstream periodic CDC synchroniser can sample it safely into the host/PCIe clock domain. The block sits directly upstream of that synchroniser.

Parameters:
W, 32, width of every counter and snapshot output; wraps modulo 2^W
SNAP_PERIOD, 64, cycles between snapshot updates; legal range 16..65535 (at least 16 so the downstream 8-cycle sampler always sees a stable value)
LEN_W, 16, width of the per-frame byte accumulator

Ports:
clk  in  1  MAC-domain clock
rst  in  1  reset, asynchronous, active-high
rx_data_valid  in  8  byte-lane valids for the current beat; any bit pattern is allowed and bytes = popcount
rx_good_frame  in  1  single-cycle end-of-frame marker, frame good
rx_bad_frame  in  1  single-cycle end-of-frame marker, frame bad
clr  in  1  single-cycle pulse; zeroes all live counters
good_frames_out  out  W  snapshot of the good-frame count
bad_frames_out  out  W  snapshot of the bad-frame count
good_bytes_out  out  W  snapshot of the good-byte count
snap_stb  out  1  one-cycle pulse in the cycle the snapshot outputs change

Behaviour:
- Reset (async assert, sync-clean deassert): all live counters, the frame accumulator, the period counter, all outputs and snap_stb are 0. FSM enters IDLE.
- FSM states: IDLE (no frame open) and IN_FRAME (bytes accumulated).
  - IDLE -> IN_FRAME on any nonzero rx_data_valid with no end marker in the same cycle.
  - IN_FRAME -> IDLE on either end marker.
  - An end marker in IDLE is still counted. Its byte total is the bytes in that cycle only.
- Accumulator:
  - acc_next = acc + popcount(rx_data_valid), saturating at 2^LEN_W-1.
  - Bytes in the end-marker cycle are included in the frame.
- Commit, in the end-marker cycle:
  - good marker: good_frames += 1 and good_bytes += acc_next (zero-extended, wraps).
  - bad marker: bad_frames += 1; the bytes are discarded.
  - Both markers in the same cycle: treated as bad.
  - The accumulator returns to 0 in the cycle after the marker.
- clr: zeroes live counters and the accumulator, and forces IDLE next cycle. It overrides a commit in the same cycle, so that frame is lost. Snapshot outputs are unaffected until the next snapshot.
- Snapshot:
  - The period counter runs 0..SNAP_PERIOD-1 and wraps.
  - At terminal count, the outputs load the live counter values as registered at the start of that cycle (pre-update). snap_stb is registered alongside, so outputs and snap_stb change together on the following edge.
  - The first snapshot occurs SNAP_PERIOD cycles after reset release.
  - Outputs are otherwise held constant.
- Counter wrap: all-ones + 1 = 0, with no sticky flag.
- Latency: a commit at cycle t appears in the outputs at the first snapshot with terminal cycle > t.

Decomposition:
- Shared package: FSM state encodings (IDLE, IN_FRAME) and the SNAP_PERIOD legality bound constant.
- Sub-module byte_lane_count: combinational 8-bit popcount returning 4 bits.
- Everything else stays in rx_stats_counter.

Test Plan:
1. Reset then idle for 200 cycles -> all outputs 0. snap_stb pulses at cycles 64, 128 and 192 after release, each 1 cycle wide.
2. Good frame: 8 beats of 0xFF, then a final beat of 0x0F with rx_good_frame -> next snapshot shows good_frames=1, good_bytes=68, bad_frames=0.
3. Bad frame: 4 beats of 0xFF, then rx_bad_frame alone -> bad_frames=1 and good_bytes is unchanged. rx_good_frame and rx_bad_frame asserted together on a 2-beat frame -> bad_frames=2.
4. Preload good_frames to 2^W-1 (W=8 build), then 1 good frame -> snapshot good_frames=0.
5. clr in the same cycle as rx_good_frame of a 60-byte frame -> the next snapshot after the clr shows all 0. Outputs held their pre-clr values until that snapshot.
6. Assert rst mid-frame, then 3 good 64-byte frames -> outputs go to 0 immediately on rst assertion, and the later snapshot shows good_frames=3, good_bytes=192.
